ckpt_map_table: RTL and testbench
=================================

# ckpt_map_table

Speculative register alias table with internal branch checkpoints, a committed architectural map, and a per-physical-register ready vector. It sits between decode/free list and RS/ROB. It renames up to DISPATCH_WIDTH instructions per cycle with in-group dependency forwarding. Branch checkpoints are allocated in program order and recovered in one cycle on mispredict; a full flush recovers from the committed map.

## Interface
- ARCH_REGS, 32, architectural registers; arch reg 0 hardwired
- PHYS_REGS, 64, physical registers; must be ≥ ARCH_REGS
- DISPATCH_WIDTH, 2, rename slots per cycle
- WB_WIDTH, 4, writeback ports
- COMMIT_WIDTH, 2, commit ports
- NUM_CKPT, 4, checkpoint slots; power of 2
- Widths: AW = $clog2(ARCH_REGS), PW = $clog2(PHYS_REGS), CW = $clog2(NUM_CKPT)

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high
- rs1_arch_i, rs2_arch_i  in  [DW][AW]  source arch regs per slot
- rs1_phys_o, rs2_phys_o  out  [DW][PW]  mapped tags (comb)
- rs1_ready_o, rs2_ready_o  out  [DW]  tag value ready (comb)
- disp_valid_i  in  [DW]  slot renames its destination
- disp_arch_i  in  [DW][AW]  destination arch reg
- disp_new_phys_i  in  [DW][PW]  tag from free list
- disp_old_phys_o  out  [DW][PW]  previous mapping of dest, to ROB (comb)
- disp_br_i  in  [DW]  slot is a branch; at most one bit set per cycle
- ckpt_id_o  out  CW  checkpoint id for this cycle's branch (comb)
- ckpt_full_o  out  1  no free checkpoint (registered state)
- wb_valid_i  in  [WB]  writeback strobe
- wb_phys_i  in  [WB][PW]  tag written back
- br_resolve_i  in  1  branch resolved
- br_mispred_i  in  1  qualifies br_resolve_i
- br_ckpt_i  in  CW  checkpoint id of resolved branch
- commit_valid_i  in  [CM]  commit strobe, oldest at index 0
- commit_arch_i  in  [CM][AW]  committed dest arch reg
- commit_phys_i  in  [CM][PW]  committed dest tag
- flush_i  in  1  exception/full flush

## Operation
- State: spec map [ARCH_REGS][PW], arch map [ARCH_REGS][PW], ready [PHYS_REGS], ckpt array [NUM_CKPT][ARCH_REGS][PW] with done bits, head/tail pointers and a count.
- Lookup for slot i: start from the spec map. Override with the newest disp_valid slot j<i whose disp_arch_i matches; the result is disp_new_phys_i[j] with ready=0. Otherwise ready = ready[tag] OR any wb_valid_i with an equal tag that cycle. Arch reg 0 always returns tag 0, ready=1.
- disp_old_phys_o[i]: same in-group forwarding as lookup, applied to disp_arch_i[i]. Slots with disp_arch_i=0 perform no rename; old_phys=0.
- Rename at posedge: the spec map takes the newest slot's tag per arch reg, and ready[new_phys] <= 0.
- WB at posedge: ready[wb_phys] <= 1. Same-cycle dispatch clear of the same tag wins (that tag has been reallocated).
- Checkpoint alloc: when branch slot b dispatches, write the map as it stands after slots 0..b into ckpt[tail], with done=0. Then tail++ and count++. ckpt_id_o = tail. Dispatching a branch while ckpt_full_o=1 is illegal (upstream stalls); assert.
- Correct resolve: done[br_ckpt_i] <= 1. Head pops at most one done entry per cycle: head++, count--.
- Mispredict: spec map <= ckpt[br_ckpt_i]; tail <= br_ckpt_i; count <= br_ckpt_i - head (mod NUM_CKPT). This frees that checkpoint and all younger ones. That cycle's dispatch is dropped: no map update, no ready clear, no alloc. The ready vector is not restored.
- Commit: arch map[commit_arch] <= commit_phys in slot order (higher index wins). Arch reg 0 is ignored.
- Flush: spec map <= arch map including same-cycle commits. Checkpoints emptied (head=tail=0, count=0). ready all set to 1. Dispatch and resolve that cycle are ignored.
- Priority: flush > mispredict > correct resolve/pop > dispatch. WB and commit always apply.

## Timing
- Lookup, disp_old_phys_o and ckpt_id_o are combinational, zero latency. Every state update is visible the cycle after the posedge.
- Reset (async): spec and arch maps identity (i→i), all ready=1, head=tail=count=0, all done=0, ckpt_full_o=0. Combinational outputs reflect the identity map immediately.
- ckpt_full_o = (count==NUM_CKPT). It deasserts the cycle after a pop, mispredict or flush.
- Pointers wrap modulo NUM_CKPT. Alloc and pop in the same cycle leave count unchanged.
- A mispredict on a non-allocated id is illegal; assert. A mispredict on the head entry with done=1 cannot occur.

## Test plan
- Reset, then read rs1=5 → phys 5, ready 1. Assert reset mid-operation → identity map restored immediately.
- Same-cycle pair: slot0 r3←p40, slot1 reads r3 and renames r3←p41 → slot1 rs1=p40 ready 0, old_phys=p40. Next cycle r3 maps to p41.
- WB p41 while slot0 reads r3 (mapped to p41) → ready=1 same cycle. WB p41 with dispatch of new_phys=p41 → ready[41]=0 next cycle.
- Fill 4 checkpoints → ckpt_full_o=1. Correct resolve of id 0 → full drops 1 cycle later. Next branch receives id 0 (wrap).
- Branch id 1 with r7←p50 after it, then mispredict id 1 → r7 returns its pre-p50 tag; ids 1..3 freed; count=1; the same-cycle dispatch is ignored.
- Commit r9←p60, then flush → r9 maps to p60; all other regs at their committed tags; all ready=1; ckpt_full_o=0.

Source files
------------

// File: rtl/ckpt_map_table.sv
// Speculative register alias table with in-order branch checkpoints, a committed
// architectural map and a per-physical-register ready vector.
module ckpt_map_table #(
  parameter int unsigned ARCH_REGS      = 32,
  parameter int unsigned PHYS_REGS      = 64,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned WB_WIDTH       = 4,
  parameter int unsigned COMMIT_WIDTH   = 2,
  parameter int unsigned NUM_CKPT       = 4,
  localparam int unsigned AW  = $clog2(ARCH_REGS),
  localparam int unsigned PW  = $clog2(PHYS_REGS),
  localparam int unsigned CW  = $clog2(NUM_CKPT),
  localparam int unsigned CTW = CW + 1,
  localparam int unsigned DW  = DISPATCH_WIDTH,
  localparam int unsigned WBW = WB_WIDTH,
  localparam int unsigned CMW = COMMIT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DW-1:0][AW-1:0]  rs1_arch_i,
  input  logic [DW-1:0][AW-1:0]  rs2_arch_i,
  output logic [DW-1:0][PW-1:0]  rs1_phys_o,
  output logic [DW-1:0][PW-1:0]  rs2_phys_o,
  output logic [DW-1:0]          rs1_ready_o,
  output logic [DW-1:0]          rs2_ready_o,
  input  logic [DW-1:0]          disp_valid_i,
  input  logic [DW-1:0][AW-1:0]  disp_arch_i,
  input  logic [DW-1:0][PW-1:0]  disp_new_phys_i,
  output logic [DW-1:0][PW-1:0]  disp_old_phys_o,
  input  logic [DW-1:0]          disp_br_i,
  output logic [CW-1:0]          ckpt_id_o,
  output logic                   ckpt_full_o,
  input  logic [WBW-1:0]         wb_valid_i,
  input  logic [WBW-1:0][PW-1:0] wb_phys_i,
  input  logic                   br_resolve_i,
  input  logic                   br_mispred_i,
  input  logic [CW-1:0]          br_ckpt_i,
  input  logic [CMW-1:0]         commit_valid_i,
  input  logic [CMW-1:0][AW-1:0] commit_arch_i,
  input  logic [CMW-1:0][PW-1:0] commit_phys_i,
  input  logic                   flush_i
);

  typedef logic [PW-1:0] map_t [ARCH_REGS];

  map_t                 spec_q, spec_d, arch_q, arch_d, snap;
  map_t                 ckpt_q [NUM_CKPT];
  logic [PHYS_REGS-1:0] ready_q, ready_d;
  logic [NUM_CKPT-1:0]  done_q, done_d;
  logic [CW-1:0]        head_q, head_d, tail_q, tail_d, mis_off;
  logic [CTW-1:0]       count_q, count_d;
  logic                 full_q, full_d;
  logic                 mispred, disp_en, alloc, resolve_ok, pop;
  logic [AW-1:0]        src;
  logic [PW-1:0]        tag;
  logic                 rdy;

  // Source lookup with in-group forwarding and same-cycle writeback bypass
  always_comb begin
    rs1_phys_o  = '0;
    rs2_phys_o  = '0;
    rs1_ready_o = '0;
    rs2_ready_o = '0;
    src = '0;
    tag = '0;
    rdy = 1'b0;
    for (int i = 0; i < int'(DW); i++) begin
      for (int s = 0; s < 2; s++) begin
        src = (s == 0) ? rs1_arch_i[i] : rs2_arch_i[i];
        tag = spec_q[src];
        rdy = ready_q[tag];
        for (int w = 0; w < int'(WBW); w++)
          if (wb_valid_i[w] && (wb_phys_i[w] == tag)) rdy = 1'b1;
        for (int j = 0; j < i; j++)
          if (disp_valid_i[j] && (disp_arch_i[j] == src)) begin
            tag = disp_new_phys_i[j];
            rdy = 1'b0;
          end
        if (src == '0) begin
          tag = '0;
          rdy = 1'b1;
        end
        if (s == 0) begin
          rs1_phys_o[i]  = tag;
          rs1_ready_o[i] = rdy;
        end else begin
          rs2_phys_o[i]  = tag;
          rs2_ready_o[i] = rdy;
        end
      end
    end
  end

  // Previous mapping of each destination, seen through older slots of the group
  always_comb begin
    disp_old_phys_o = '0;
    for (int i = 0; i < int'(DW); i++) begin
      if (disp_arch_i[i] != '0) begin
        disp_old_phys_o[i] = spec_q[disp_arch_i[i]];
        for (int j = 0; j < i; j++)
          if (disp_valid_i[j] && (disp_arch_i[j] == disp_arch_i[i]))
            disp_old_phys_o[i] = disp_new_phys_i[j];
      end
    end
  end

  assign ckpt_id_o   = tail_q;
  assign ckpt_full_o = full_q;

  always_comb begin
    spec_d     = spec_q;
    arch_d     = arch_q;
    snap       = spec_q;
    ready_d    = ready_q;
    done_d     = done_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mispred    = br_resolve_i && br_mispred_i;
    disp_en    = !flush_i && !mispred;
    alloc      = disp_en && (|disp_br_i);
    resolve_ok = !flush_i && br_resolve_i && !br_mispred_i;
    mis_off    = br_ckpt_i - head_q;

    for (int k = 0; k < int'(CMW); k++)
      if (commit_valid_i[k] && (commit_arch_i[k] != '0))
        arch_d[commit_arch_i[k]] = commit_phys_i[k];
    for (int w = 0; w < int'(WBW); w++)
      if (wb_valid_i[w]) ready_d[wb_phys_i[w]] = 1'b1;

    // Dispatch clear runs after writeback so a reallocated tag stays not-ready
    if (disp_en) begin
      for (int i = 0; i < int'(DW); i++) begin
        if (disp_valid_i[i] && (disp_arch_i[i] != '0)) begin
          spec_d[disp_arch_i[i]]      = disp_new_phys_i[i];
          ready_d[disp_new_phys_i[i]] = 1'b0;
        end
        if (disp_br_i[i]) snap = spec_d;
      end
    end

    if (resolve_ok) done_d[br_ckpt_i] = 1'b1;
    pop = !flush_i && !mispred && (count_q != '0) && done_d[head_q];
    if (pop) begin
      done_d[head_q] = 1'b0;
      head_d         = head_q + CW'(1);
    end
    if (alloc) begin
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + CW'(1);
    end
    count_d = count_q + CTW'(alloc) - CTW'(pop);

    if (mispred) begin
      spec_d  = ckpt_q[br_ckpt_i];
      tail_d  = br_ckpt_i;
      count_d = CTW'(mis_off);
    end

    if (flush_i) begin
      spec_d  = arch_d;
      ready_d = '1;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    full_d = (count_d == CTW'(NUM_CKPT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < int'(ARCH_REGS); a++) begin
        spec_q[a] <= PW'(a);
        arch_q[a] <= PW'(a);
      end
      ready_q <= '1;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      spec_q  <= spec_d;
      arch_q  <= arch_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Checkpoint storage needs no reset; only allocated slots are ever read
  always_ff @(posedge clock) begin
    if (alloc) ckpt_q[tail_q] <= snap;
  end

  a_br_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(disp_br_i));
  a_br_when_full: assert property (@(posedge clock) disable iff (reset)
    !(alloc && full_q));
  a_mispred_alloc: assert property (@(posedge clock) disable iff (reset)
    !(mispred && !flush_i && (CTW'(mis_off) >= count_q)));

endmodule

// File: tb/tb_ckpt_map_table.sv
// Directed scoreboard bench for ckpt_map_table: expectations are queued with the
// stimulus and popped against the outputs at the falling edge.
module tb_ckpt_map_table;

  logic            clock, reset;
  logic [1:0][4:0] rs1_arch, rs2_arch, disp_arch;
  logic [1:0][5:0] rs1_phys, rs2_phys, disp_new, disp_old;
  logic [1:0]      rs1_ready, rs2_ready, disp_valid, disp_br;
  logic [1:0]      ckpt_id;
  logic            ckpt_full;
  logic [3:0]      wb_valid;
  logic [3:0][5:0] wb_phys;
  logic            br_resolve, br_mispred, flush;
  logic [1:0]      br_ckpt;
  logic [1:0]      commit_valid;
  logic [1:0][4:0] commit_arch;
  logic [1:0][5:0] commit_phys;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int S_R1P0 = 0, S_R1R0 = 1, S_R1P1 = 2, S_R1R1 = 3;
  localparam int S_R2P0 = 4, S_R2R0 = 5, S_R2P1 = 6, S_R2R1 = 7;
  localparam int S_OLD0 = 8, S_OLD1 = 9, S_CKID = 10, S_FULL = 11;

  string tag_q[$];
  int    sel_q[$];
  int    val_q[$];

  ckpt_map_table dut (
    .clock(clock), .reset(reset),
    .rs1_arch_i(rs1_arch), .rs2_arch_i(rs2_arch),
    .rs1_phys_o(rs1_phys), .rs2_phys_o(rs2_phys),
    .rs1_ready_o(rs1_ready), .rs2_ready_o(rs2_ready),
    .disp_valid_i(disp_valid), .disp_arch_i(disp_arch),
    .disp_new_phys_i(disp_new), .disp_old_phys_o(disp_old),
    .disp_br_i(disp_br), .ckpt_id_o(ckpt_id), .ckpt_full_o(ckpt_full),
    .wb_valid_i(wb_valid), .wb_phys_i(wb_phys),
    .br_resolve_i(br_resolve), .br_mispred_i(br_mispred), .br_ckpt_i(br_ckpt),
    .commit_valid_i(commit_valid), .commit_arch_i(commit_arch),
    .commit_phys_i(commit_phys), .flush_i(flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int read_sig(input int sel);
    case (sel)
      S_R1P0: return int'(rs1_phys[0]);
      S_R1R0: return int'(rs1_ready[0]);
      S_R1P1: return int'(rs1_phys[1]);
      S_R1R1: return int'(rs1_ready[1]);
      S_R2P0: return int'(rs2_phys[0]);
      S_R2R0: return int'(rs2_ready[0]);
      S_R2P1: return int'(rs2_phys[1]);
      S_R2R1: return int'(rs2_ready[1]);
      S_OLD0: return int'(disp_old[0]);
      S_OLD1: return int'(disp_old[1]);
      S_CKID: return int'(ckpt_id);
      default: return int'(ckpt_full);
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int sel, input int val);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    val_q.push_back(val);
  endtask

  task automatic expect_src(input string tag, input int psel, input int p, input int r);
    expect_sig({tag, "_phys"}, psel, p);
    expect_sig({tag, "_rdy"}, psel + 1, r);
  endtask

  task automatic compare_all();
    string t;
    int s, v;
    while (sel_q.size() != 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      v = val_q.pop_front();
      check_eq(t, read_sig(s), v);
    end
  endtask

  task automatic idle();
    rs1_arch = '0; rs2_arch = '0; disp_arch = '0; disp_new = '0;
    disp_valid = '0; disp_br = '0; wb_valid = '0; wb_phys = '0;
    br_resolve = 1'b0; br_mispred = 1'b0; br_ckpt = '0; flush = 1'b0;
    commit_valid = '0; commit_arch = '0; commit_phys = '0;
  endtask

  task automatic tick();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic dispatch(input int slot, input int arch, input int phys);
    disp_valid[slot] = 1'b1;
    disp_arch[slot]  = 5'(arch);
    disp_new[slot]   = 6'(phys);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    rs1_arch[0] = 5'd5;
    expect_src("reset_r5", S_R1P0, 5, 1);
    expect_sig("reset_full", S_FULL, 0);
    expect_sig("reset_ckid", S_CKID, 0);
    tick();
    @(posedge clock); #1;
    reset = 1'b0;

    // identity reads and hardwired r0
    rs1_arch[0] = 5'd5;
    rs2_arch[1] = 5'd0;
    expect_src("c1_r5", S_R1P0, 5, 1);
    expect_src("c1_r0", S_R2P1, 0, 1);
    tick();

    // same-cycle pair r3<-p40, r3<-p41 with in-group forwarding
    rs1_arch[0] = 5'd3;
    rs1_arch[1] = 5'd3;
    dispatch(0, 3, 40);
    dispatch(1, 3, 41);
    expect_src("c2_s0_r3", S_R1P0, 3, 1);
    expect_src("c2_s1_fwd", S_R1P1, 40, 0);
    expect_sig("c2_old0", S_OLD0, 3);
    expect_sig("c2_old1", S_OLD1, 40);
    tick();

    rs1_arch[0] = 5'd3;
    expect_src("c3_r3", S_R1P0, 41, 0);
    tick();

    // writeback bypass, and same-cycle reallocation of the written tag
    rs1_arch[0] = 5'd3;
    wb_valid[2] = 1'b1;
    wb_phys[2]  = 6'd41;
    dispatch(0, 4, 41);
    expect_src("c4_wb_byp", S_R1P0, 41, 1);
    expect_sig("c4_old0", S_OLD0, 4);
    tick();

    rs1_arch[0] = 5'd3;
    rs2_arch[0] = 5'd4;
    expect_src("c5_r3_clr", S_R1P0, 41, 0);
    expect_src("c5_r4", S_R2P0, 41, 0);
    tick();

    // four checkpoints; id1 snapshot precedes r7<-p50 in the same group
    disp_br[0] = 1'b1;
    expect_sig("c6_ckid", S_CKID, 0);
    tick();

    disp_br[0] = 1'b1;
    dispatch(1, 7, 50);
    expect_sig("c7_ckid", S_CKID, 1);
    expect_sig("c7_old1", S_OLD1, 7);
    tick();

    disp_br[1] = 1'b1;
    dispatch(0, 8, 51);
    rs1_arch[0] = 5'd7;
    rs1_arch[1] = 5'd8;
    expect_sig("c8_ckid", S_CKID, 2);
    expect_src("c8_r7", S_R1P0, 50, 0);
    expect_src("c8_r8_fwd", S_R1P1, 51, 0);
    expect_sig("c8_old0", S_OLD0, 8);
    tick();

    disp_br[0] = 1'b1;
    expect_sig("c9_ckid", S_CKID, 3);
    expect_sig("c9_full", S_FULL, 0);
    tick();

    // mispredict id1 with a dispatch that must be dropped
    expect_sig("c10_full", S_FULL, 1);
    expect_sig("c10_ckid", S_CKID, 0);
    br_resolve = 1'b1;
    br_mispred = 1'b1;
    br_ckpt    = 2'd1;
    dispatch(0, 7, 52);
    dispatch(1, 9, 53);
    tick();

    rs1_arch[0] = 5'd7;
    rs1_arch[1] = 5'd8;
    rs2_arch[0] = 5'd3;
    rs2_arch[1] = 5'd9;
    expect_src("c11_r7_rest", S_R1P0, 7, 1);
    expect_src("c11_r8_rest", S_R1P1, 8, 1);
    expect_src("c11_r3", S_R2P0, 41, 0);
    expect_src("c11_r9_drop", S_R2P1, 9, 1);
    expect_sig("c11_full", S_FULL, 0);
    expect_sig("c11_ckid", S_CKID, 1);
    disp_br[0] = 1'b1;
    tick();

    disp_br[0] = 1'b1;
    expect_sig("c12_ckid", S_CKID, 2);
    tick();

    disp_br[1] = 1'b1;
    expect_sig("c13_ckid", S_CKID, 3);
    expect_sig("c13_full", S_FULL, 0);
    tick();

    // count was 1 after the mispredict, so three more fill the table
    expect_sig("c14_full", S_FULL, 1);
    expect_sig("c14_ckid", S_CKID, 0);
    br_resolve = 1'b1;
    br_ckpt    = 2'd0;
    tick();

    expect_sig("c15_full", S_FULL, 0);
    expect_sig("c15_ckid_wrap", S_CKID, 0);
    disp_br[0] = 1'b1;
    tick();

    expect_sig("c16_full", S_FULL, 1);
    expect_sig("c16_ckid", S_CKID, 1);
    tick();

    // commits (higher slot wins) then flush with same-cycle commit
    dispatch(0, 9, 60);
    commit_valid = 2'b11;
    commit_arch[0] = 5'd3; commit_phys[0] = 6'd40;
    commit_arch[1] = 5'd3; commit_phys[1] = 6'd41;
    tick();

    commit_valid = 2'b11;
    commit_arch[0] = 5'd9; commit_phys[0] = 6'd60;
    commit_arch[1] = 5'd0; commit_phys[1] = 6'd61;
    flush = 1'b1;
    br_resolve = 1'b1;
    br_ckpt    = 2'd1;
    dispatch(0, 10, 62);
    tick();

    rs1_arch[0] = 5'd9;
    rs2_arch[0] = 5'd3;
    rs1_arch[1] = 5'd4;
    rs2_arch[1] = 5'd10;
    expect_src("c19_r9", S_R1P0, 60, 1);
    expect_src("c19_r3", S_R2P0, 41, 1);
    expect_src("c19_r4", S_R1P1, 4, 1);
    expect_src("c19_r10", S_R2P1, 10, 1);
    expect_sig("c19_full", S_FULL, 0);
    expect_sig("c19_ckid", S_CKID, 0);
    expect_sig("c19_old0", S_OLD0, 5);
    dispatch(0, 5, 33);
    disp_br[0] = 1'b1;
    tick();

    // asynchronous reset mid-cycle restores identity immediately
    rs1_arch[0] = 5'd5;
    expect_src("c20_r5", S_R1P0, 33, 0);
    expect_sig("c20_ckid", S_CKID, 1);
    @(negedge clock);
    compare_all();
    #1 reset = 1'b1;
    #1;
    expect_src("async_r5", S_R1P0, 5, 1);
    expect_sig("async_ckid", S_CKID, 0);
    expect_sig("async_full", S_FULL, 0);
    compare_all();
    @(posedge clock); #1;
    reset = 1'b0;
    idle();

    rs1_arch[0] = 5'd3;
    rs1_arch[1] = 5'd9;
    expect_src("post_r3", S_R1P0, 3, 1);
    expect_src("post_r9", S_R1P1, 9, 1);
    tick();

    check_eq("sb_empty", sel_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
